// File: rtl/div6x3_seq_pkg.sv
// Shared definitions for the 6-by-3 sequential restoring divider:
// operand widths, iteration counter width and the control FSM state type.
package div_pkg;

  localparam int N_DVD = 6;
  localparam int N_DVS = 3;
  localparam int CNT_W = $clog2(N_DVD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div6x3_seq_if.sv
// Request/result bundle of the divider; the requester drives start/p/b and
// the divider returns status and results.
interface div6x3_seq_if;
  import div_pkg::*;

  logic             start;
  logic [N_DVD-1:0] p;
  logic [N_DVS-1:0] b;
  logic             busy;
  logic             done;
  logic [N_DVD-1:0] q;
  logic [N_DVS-1:0] r;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, p, b,
    input  busy, done, q, r, dbz, ovf
  );

  modport slave (
    input  start, p, b,
    output busy, done, q, r, dbz, ovf
  );

endinterface

// File: rtl/div6x3_seq_step.sv
// One restoring-division step: compare the widened partial remainder with
// the divisor and subtract when it fits.
module div_step
  import div_pkg::*;
(
  input  logic [N_DVS:0]   rem_in,
  input  logic [N_DVS-1:0] dvs,
  output logic [N_DVS-1:0] rem_out,
  output logic             qbit
);

  logic [N_DVS:0] diff;

  // rem_in is always below 2*dvs, so the difference fits back into N_DVS bits
  always_comb begin
    diff    = rem_in - {1'b0, dvs};
    qbit    = (rem_in >= {1'b0, dvs});
    rem_out = qbit ? diff[N_DVS-1:0] : rem_in[N_DVS-1:0];
  end

endmodule

// File: rtl/div6x3_seq.sv
// Sequential restoring divider: 6-bit dividend by 3-bit divisor, one quotient
// bit per clock, with divide-by-zero and wide-quotient flags.
module div6x3_seq
  import div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  div6x3_seq_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [N_DVD-1:0] dvd_q;
  logic [N_DVS-1:0] dvs_q;
  logic [N_DVS-1:0] rem_q;
  logic [N_DVD-1:0] q_q;
  logic [N_DVS-1:0] r_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [N_DVS:0]   rem_shift;
  logic [N_DVS-1:0] rem_next;
  logic             qbit;
  logic [N_DVD-1:0] q_next;
  logic             last_step;
  logic             busy;
  logic             done;

  assign rem_shift = {rem_q, dvd_q[N_DVD-1]};
  assign q_next    = {dvd_q[N_DVD-2:0], qbit};
  assign last_step = (cnt_q == '0);

  div_step u_step (
    .rem_in  (rem_shift),
    .dvs     (dvs_q),
    .rem_out (rem_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.b != '0) ? RUN : DONE;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Results are registered on the way into DONE so they are valid with the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.b != '0) begin
              dvd_q <= bus.p;
              dvs_q <= bus.b;
              rem_q <= '0;
              cnt_q <= CNT_W'(N_DVD - 1);
            end else begin
              q_q   <= '1;
              r_q   <= '0;
              dbz_q <= 1'b1;
              ovf_q <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_q <= q_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_step) begin
            q_q   <= q_next;
            r_q   <= rem_next;
            dbz_q <= 1'b0;
            ovf_q <= |q_next[N_DVD-1:N_DVS];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.dbz  = dbz_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_div6x3_seq.sv
// Directed and table-driven bench for the 6-by-3 sequential divider:
// latency, flags, ignored restarts, mid-run reset and the q*b+r==p identity.
module tb_div6x3_seq;

  logic clk;
  logic rst;

  div6x3_seq_if bus ();

  div6x3_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] p;
    logic [2:0] b;
    logic [5:0] q;
    logic [2:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
    int         busy_cycles;
  } vec_t;

  vec_t vecs[9];

  int n_checks;
  int n_fail;

  int         lat;
  int         busy_cnt;
  logic       got_done;
  logic [5:0] res_q;
  logic [2:0] res_r;
  logic       res_dbz;
  logic       res_ovf;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issues one request and waits (bounded) for the done pulse; returns at the
  // falling edge of the done cycle with the results captured.
  task automatic applyStimulus(input logic [5:0] pv, input logic [2:0] bv);
    @(negedge clk);
    bus.p     = pv;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 0;
    busy_cnt  = 0;
    got_done  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat      = c;
        got_done = 1'b1;
        res_q    = bus.q;
        res_r    = bus.r;
        res_dbz  = bus.dbz;
        res_ovf  = bus.ovf;
        break;
      end
      @(negedge clk);
    end
    checkOutput("done_seen", 32'(got_done), 32'd1);
  endtask

  initial begin
    int done_cnt;
    int prod;

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.p     = '0;
    bus.b     = '0;

    vecs[0] = '{6'd42, 3'd6, 6'd7,  3'd0, 1'b0, 1'b0, 7, 6};
    vecs[1] = '{6'd47, 3'd5, 6'd9,  3'd2, 1'b0, 1'b1, 7, 6};
    vecs[2] = '{6'd63, 3'd1, 6'd63, 3'd0, 1'b0, 1'b1, 7, 6};
    vecs[3] = '{6'd5,  3'd0, 6'd63, 3'd0, 1'b1, 1'b1, 1, 0};
    vecs[4] = '{6'd0,  3'd3, 6'd0,  3'd0, 1'b0, 1'b0, 7, 6};
    vecs[5] = '{6'd7,  3'd7, 6'd1,  3'd0, 1'b0, 1'b0, 7, 6};
    vecs[6] = '{6'd62, 3'd7, 6'd8,  3'd6, 1'b0, 1'b1, 7, 6};
    vecs[7] = '{6'd20, 3'd3, 6'd6,  3'd2, 1'b0, 1'b0, 7, 6};
    vecs[8] = '{6'd55, 3'd4, 6'd13, 3'd3, 1'b0, 1'b1, 7, 6};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_q",    32'(bus.q),    32'd0);
    checkOutput("reset_r",    32'(bus.r),    32'd0);
    checkOutput("reset_dbz",  32'(bus.dbz),  32'd0);
    checkOutput("reset_ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].p, vecs[i].b);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat),      32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_busy", i),    32'(busy_cnt), 32'(vecs[i].busy_cycles));
      checkOutput($sformatf("vec%0d_q", i),       32'(res_q),    32'(vecs[i].q));
      checkOutput($sformatf("vec%0d_r", i),       32'(res_r),    32'(vecs[i].r));
      checkOutput($sformatf("vec%0d_dbz", i),     32'(res_dbz),  32'(vecs[i].dbz));
      checkOutput($sformatf("vec%0d_ovf", i),     32'(res_ovf),  32'(vecs[i].ovf));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      checkOutput($sformatf("vec%0d_q_hold", i),     32'(bus.q),    32'(vecs[i].q));
    end

    // A second start during a run must be ignored entirely
    @(negedge clk);
    bus.p     = 6'd42;
    bus.b     = 3'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt  = 0;
    lat       = 0;
    res_q     = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) begin
        bus.p     = 6'd13;
        bus.b     = 3'd2;
        bus.start = 1'b1;
      end
      if (c == 4) bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++;
        lat   = c;
        res_q = bus.q;
        res_r = bus.r;
      end
      @(negedge clk);
    end
    checkOutput("restart_done_count", 32'(done_cnt), 32'd1);
    checkOutput("restart_latency",    32'(lat),      32'd7);
    checkOutput("restart_q",          32'(res_q),    32'd7);
    checkOutput("restart_r",          32'(res_r),    32'd0);

    // Reset in the middle of a run aborts without a done pulse
    bus.p     = 6'd42;
    bus.b     = 3'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_q",    32'(bus.q),    32'd0);
    checkOutput("midrst_r",    32'(bus.r),    32'd0);
    checkOutput("midrst_dbz",  32'(bus.dbz),  32'd0);
    checkOutput("midrst_ovf",  32'(bus.ovf),  32'd0);
    rst      = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(6'd47, 3'd5);
    checkOutput("postrst_q",   32'(res_q),   32'd9);
    checkOutput("postrst_r",   32'(res_r),   32'd2);
    checkOutput("postrst_ovf", 32'(res_ovf), 32'd1);

    // Products of two 3-bit operands must divide back exactly
    for (int a = 1; a <= 7; a++) begin
      for (int bb = 1; bb <= 7; bb++) begin
        applyStimulus(6'(a * bb), 3'(bb));
        checkOutput($sformatf("sweep_%0dx%0d_q", a, bb),   32'(res_q),   32'(a));
        checkOutput($sformatf("sweep_%0dx%0d_r", a, bb),   32'(res_r),   32'd0);
        checkOutput($sformatf("sweep_%0dx%0d_ovf", a, bb), 32'(res_ovf), 32'd0);
      end
    end

    for (int k = 0; k < 40; k++) begin
      logic [5:0] rp;
      logic [2:0] rb;
      rp = 6'($urandom_range(0, 63));
      rb = 3'($urandom_range(1, 7));
      applyStimulus(rp, rb);
      prod = int'(res_q) * int'(rb) + int'(res_r);
      checkOutput($sformatf("rand%0d_identity", k), 32'(prod), 32'(rp));
      checkOutput($sformatf("rand%0d_r_lt_b", k), 32'(res_r < rb), 32'd1);
      checkOutput($sformatf("rand%0d_ovf", k), 32'(res_ovf), 32'(res_q > 6'd7));
      checkOutput($sformatf("rand%0d_dbz", k), 32'(res_dbz), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
